// File: rtl/nn_feeder.sv
// Instruction-driven front end: fills per-lane input/weight FIFOs, then streams
// them into the systolic array with a one-cycle-per-lane diagonal skew.
module nn_feeder #(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [2:0]          instr_op,
  input  logic [AW-1:0]       instr_addr,
  input  logic [DW-1:0]       instr_data,
  output logic [LANES*DW-1:0] feed_data,
  output logic [LANES-1:0]    feed_valid,
  output logic [LANES*DW-1:0] weight_data,
  output logic [LANES-1:0]    weight_valid,
  output logic [DW-1:0]       bias_data,
  output logic                bias_load,
  output logic                switch_out,
  output logic                busy,
  output logic                err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(DEPTH + LANES) + 1;

  localparam logic [2:0] OP_LOAD_IN = 3'd1, OP_LOAD_W = 3'd2, OP_LOAD_BIAS = 3'd3,
                         OP_RUN_IN = 3'd4, OP_RUN_W = 3'd5, OP_SWITCH = 3'd6, OP_CLEAR = 3'd7;

  typedef enum logic [1:0] {IDLE, STREAM_IN, STREAM_W} state_t;

  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  // Index 0 holds the input FIFOs, index 1 the weight FIFOs.
  logic [DW-1:0] mem_q [2][LANES][DEPTH];
  logic [DW-1:0] mem_d [2][LANES][DEPTH];
  logic [PW-1:0] rd_q [2][LANES], rd_d [2][LANES];
  logic [PW-1:0] wr_q [2][LANES], wr_d [2][LANES];
  logic [CW-1:0] cnt_q [2][LANES], cnt_d [2][LANES];
  logic [LANES*DW-1:0] feed_data_q, feed_data_d, weight_data_q, weight_data_d;
  logic [LANES-1:0] feed_valid_q, feed_valid_d, weight_valid_q, weight_valid_d;
  logic [DW-1:0] bias_data_q, bias_data_d;
  logic bias_load_q, bias_load_d, switch_q, switch_d, busy_q, busy_d, err_q, err_d;

  logic          fw, lane_ok, lane_full, short_lane, emit_en, emit_w;
  logic [CW-1:0] run_c;

  assign instr_ready = (state_q == IDLE) && rst;

  always_comb begin
    state_d = state_q;   s_d = s_q;       run_cnt_d = run_cnt_q;
    mem_d = mem_q;       rd_d = rd_q;     wr_d = wr_q;   cnt_d = cnt_q;
    feed_valid_d = '0;   feed_data_d = '0;
    weight_valid_d = '0; weight_data_d = '0;
    bias_data_d = '0;    bias_load_d = 1'b0;
    switch_d = 1'b0;     err_d = 1'b0;
    emit_en = 1'b0;
    fw = (instr_op == OP_LOAD_W) || (instr_op == OP_RUN_W);
    run_c = instr_data[CW-1:0];
    lane_ok = 1'b0; lane_full = 1'b0; short_lane = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (instr_addr == AW'(k)) begin
        lane_ok   = 1'b1;
        lane_full = (cnt_q[fw][k] == CW'(DEPTH));
      end
      if (cnt_q[fw][k] < run_c) short_lane = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          case (instr_op)
            OP_LOAD_IN, OP_LOAD_W: begin
              if (!lane_ok || lane_full) err_d = 1'b1;
              else begin
                for (int k = 0; k < LANES; k++) begin
                  if (instr_addr == AW'(k)) begin
                    mem_d[fw][k][wr_q[fw][k]] = instr_data;
                    wr_d[fw][k]  = wr_q[fw][k] + PW'(1);
                    cnt_d[fw][k] = cnt_q[fw][k] + CW'(1);
                  end
                end
              end
            end
            OP_LOAD_BIAS: begin
              bias_data_d = instr_data;
              bias_load_d = 1'b1;
            end
            OP_RUN_IN, OP_RUN_W: begin
              if (run_c != '0) begin
                if (short_lane) err_d = 1'b1;
                else begin
                  state_d   = fw ? STREAM_W : STREAM_IN;
                  s_d       = '0;
                  run_cnt_d = run_c;
                  emit_en   = 1'b1;
                  for (int k = 0; k < LANES; k++) cnt_d[fw][k] = cnt_q[fw][k] - run_c;
                end
              end
            end
            OP_SWITCH: switch_d = 1'b1;
            OP_CLEAR: begin
              rd_d  = '{default: '0};
              wr_d  = '{default: '0};
              cnt_d = '{default: '0};
            end
            default: ;
          endcase
        end
      end
      default: begin
        if (int'(s_q) == int'(run_cnt_q) + LANES - 2) state_d = IDLE;
        else begin
          s_d     = s_q + SW'(1);
          emit_en = 1'b1;
        end
      end
    endcase

    // Outputs are computed for the skew step the registers will hold next cycle.
    emit_w = (state_d == STREAM_W);
    if (emit_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (int'(s_d) >= k && int'(s_d) < k + int'(run_cnt_d)) begin
          rd_d[emit_w][k] = rd_q[emit_w][k] + PW'(1);
          if (emit_w) begin
            weight_valid_d[k]           = 1'b1;
            weight_data_d[k*DW +: DW]   = mem_q[1][k][rd_q[1][k]];
          end else begin
            feed_valid_d[k]             = 1'b1;
            feed_data_d[k*DW +: DW]     = mem_q[0][k][rd_q[0][k]];
          end
        end
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;           s_q <= '0;           run_cnt_q <= '0;
      mem_q <= '{default: '0};   rd_q <= '{default: '0};
      wr_q <= '{default: '0};    cnt_q <= '{default: '0};
      feed_data_q <= '0;         feed_valid_q <= '0;
      weight_data_q <= '0;       weight_valid_q <= '0;
      bias_data_q <= '0;         bias_load_q <= 1'b0;
      switch_q <= 1'b0;          busy_q <= 1'b0;      err_q <= 1'b0;
    end else begin
      state_q <= state_d;        s_q <= s_d;          run_cnt_q <= run_cnt_d;
      mem_q <= mem_d;            rd_q <= rd_d;
      wr_q <= wr_d;              cnt_q <= cnt_d;
      feed_data_q <= feed_data_d;     feed_valid_q <= feed_valid_d;
      weight_data_q <= weight_data_d; weight_valid_q <= weight_valid_d;
      bias_data_q <= bias_data_d;     bias_load_q <= bias_load_d;
      switch_q <= switch_d;      busy_q <= busy_d;    err_q <= err_d;
    end
  end

  assign feed_data    = feed_data_q;
  assign feed_valid   = feed_valid_q;
  assign weight_data  = weight_data_q;
  assign weight_valid = weight_valid_q;
  assign bias_data    = bias_data_q;
  assign bias_load    = bias_load_q;
  assign switch_out   = switch_q;
  assign busy         = busy_q;
  assign err          = err_q;
endmodule

// File: tb/tb_nn_feeder.sv
// Bench for nn_feeder: a 2-lane/4-deep and a 4-lane/8-deep instance, one active at a time,
// checked every cycle against a queue-based schedule model plus hand-computed literals.
module tb_nn_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        instr_valid = 1'b0;
  logic [2:0]  instr_op = '0;
  logic [1:0]  instr_addr = '0;
  logic [15:0] instr_data = '0;

  logic        a_ready, a_bias_load, a_switch, a_busy, a_err;
  logic [15:0] a_bias;
  logic [1:0]  a_fv, a_wv;
  logic [31:0] a_fd, a_wd;
  logic        b_ready, b_bias_load, b_switch, b_busy, b_err;
  logic [15:0] b_bias;
  logic [3:0]  b_fv, b_wv;
  logic [63:0] b_fd, b_wd;

  logic        o_ready, o_bias_load, o_switch, o_busy, o_err;
  logic [15:0] o_bias;
  logic [3:0]  o_fv, o_wv;
  logic [63:0] o_fd, o_wd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nn_feeder #(.LANES(2), .DEPTH(4), .DW(16)) u_a (
    .clk(clk), .rst(rst), .instr_valid(instr_valid & ~sel), .instr_ready(a_ready),
    .instr_op(instr_op), .instr_addr(instr_addr[0:0]), .instr_data(instr_data),
    .feed_data(a_fd), .feed_valid(a_fv), .weight_data(a_wd), .weight_valid(a_wv),
    .bias_data(a_bias), .bias_load(a_bias_load), .switch_out(a_switch),
    .busy(a_busy), .err(a_err));

  nn_feeder #(.LANES(4), .DEPTH(8), .DW(16)) u_b (
    .clk(clk), .rst(rst), .instr_valid(instr_valid & sel), .instr_ready(b_ready),
    .instr_op(instr_op), .instr_addr(instr_addr), .instr_data(instr_data),
    .feed_data(b_fd), .feed_valid(b_fv), .weight_data(b_wd), .weight_valid(b_wv),
    .bias_data(b_bias), .bias_load(b_bias_load), .switch_out(b_switch),
    .busy(b_busy), .err(b_err));

  always_comb begin
    if (sel) begin
      o_ready = b_ready; o_bias_load = b_bias_load; o_switch = b_switch;
      o_busy = b_busy;   o_err = b_err;             o_bias = b_bias;
      o_fv = b_fv; o_wv = b_wv; o_fd = b_fd; o_wd = b_wd;
    end else begin
      o_ready = a_ready; o_bias_load = a_bias_load; o_switch = a_switch;
      o_busy = a_busy;   o_err = a_err;             o_bias = a_bias;
      o_fv = {2'b0, a_fv}; o_wv = {2'b0, a_wv}; o_fd = {32'b0, a_fd}; o_wd = {32'b0, a_wd};
    end
  end

  // Reference model: per-lane queues; a RUN snapshots the C head entries of every
  // lane, and lane k shows entry (s-k) while k <= s < k+C.
  int          L = 2;
  int          D = 4;
  logic [15:0] mq [2][4][$];
  logic [15:0] m_sched [4][8];
  int          m_state = 0;   // 0 idle, 1 streaming inputs, 2 streaming weights
  int          m_s = 0;
  int          m_c = 0;
  logic        m_bias_load = 0, m_switch = 0, m_err = 0;
  logic [15:0] m_bias = 0;

  task automatic model_reset();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++) mq[f][k].delete();
    m_state = 0; m_s = 0; m_c = 0;
    m_bias_load = 0; m_switch = 0; m_err = 0; m_bias = 0;
  endtask

  task automatic model_apply(input int op, input int addr, input int data);
    int f;
    int c;
    logic short_lane;
    f = (op == 2 || op == 5) ? 1 : 0;
    case (op)
      1, 2: begin
        if (addr >= L || mq[f][addr].size() == D) m_err = 1;
        else mq[f][addr].push_back(data[15:0]);
      end
      3: begin m_bias_load = 1; m_bias = data[15:0]; end
      4, 5: begin
        c = data % (2 * D);
        if (c != 0) begin
          short_lane = 0;
          for (int k = 0; k < L; k++) if (mq[f][k].size() < c) short_lane = 1;
          if (short_lane) m_err = 1;
          else begin
            m_state = f + 1; m_s = 0; m_c = c;
            for (int k = 0; k < L; k++)
              for (int i = 0; i < c; i++) m_sched[k][i] = mq[f][k].pop_front();
          end
        end
      end
      6: m_switch = 1;
      7: for (int g = 0; g < 2; g++) for (int k = 0; k < 4; k++) mq[g][k].delete();
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      m_bias_load = 0; m_switch = 0; m_err = 0; m_bias = 0;
      if (m_state != 0) begin
        if (m_s == m_c + L - 2) m_state = 0;
        else m_s++;
      end else if (instr_valid) begin
        model_apply(int'(instr_op), (L == 2) ? int'(instr_addr[0]) : int'(instr_addr),
                    int'(instr_data));
      end
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : compare
    logic [3:0]  efv, ewv;
    logic [63:0] efd, ewd;
    efv = '0; ewv = '0; efd = '0; ewd = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_state != 0 && k < L && m_s >= k && m_s < k + m_c) begin
        if (m_state == 1) begin efv[k] = 1'b1; efd[k*16 +: 16] = m_sched[k][m_s-k]; end
        else              begin ewv[k] = 1'b1; ewd[k*16 +: 16] = m_sched[k][m_s-k]; end
      end
    end
    chk("instr_ready", {63'b0, o_ready}, {63'b0, (m_state == 0) && rst});
    chk("busy", {63'b0, o_busy}, {63'b0, m_state != 0});
    chk("feed_valid", {60'b0, o_fv}, {60'b0, efv});
    chk("feed_data", o_fd, efd);
    chk("weight_valid", {60'b0, o_wv}, {60'b0, ewv});
    chk("weight_data", o_wd, ewd);
    chk("bias", {47'b0, o_bias_load, o_bias}, {47'b0, m_bias_load, m_bias});
    chk("switch_out", {63'b0, o_switch}, {63'b0, m_switch});
    chk("err", {63'b0, o_err}, {63'b0, m_err});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int op, input int addr, input int data);
    int guard;
    guard = 0;
    instr_valid = 1'b1; instr_op = op[2:0]; instr_addr = addr[1:0]; instr_data = data[15:0];
    while (m_state != 0 && guard < 64) begin tick(); guard++; end
    if (guard >= 64) begin
      n_vec++; n_err++;
      $display("FAIL handshake_timeout: op %0d never accepted", op);
    end
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_state != 0 && guard < 64) begin tick(); guard++; end
  endtask

  task automatic rand_instr();
    int r, op, data;
    r = $urandom_range(0, 99);
    data = $urandom_range(0, 65535);
    if (r < 30) op = 1;
    else if (r < 58) op = 2;
    else if (r < 70) op = 4;
    else if (r < 80) op = 5;
    else if (r < 84) op = 3;
    else if (r < 88) op = 6;
    else if (r < 91) op = 7;
    else op = 0;
    if (op == 4 || op == 5)
      data = (data & ~(2 * D - 1)) | $urandom_range(0, D + 1);
    if ($urandom_range(0, 4) == 0) tick();
    issue(op, $urandom_range(0, L - 1), data);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_busy", {63'b0, o_busy}, 64'd0);
    chk("reset_ready", {63'b0, o_ready}, 64'd0);
    rst = 1'b1;
    tick();
    chk("ready_after_reset", {63'b0, o_ready}, 64'd1);

    // Basic skewed stream, 2 lanes, C=2.
    issue(1, 0, 16'h0100); issue(1, 0, 16'h0200);
    issue(1, 1, 16'h0300); issue(1, 1, 16'h0400);
    issue(4, 0, 2);
    chk("run_t1_valid", {60'b0, o_fv}, 64'h1);
    chk("run_t1_data", o_fd, 64'h0000_0100);
    tick();
    chk("run_t2_valid", {60'b0, o_fv}, 64'h3);
    chk("run_t2_data", o_fd, 64'h0300_0200);
    tick();
    chk("run_t3_data", o_fd, 64'h0400_0000);
    chk("run_t3_busy", {63'b0, o_busy}, 64'd1);
    tick();
    chk("run_t4_ready", {63'b0, o_ready}, 64'd1);
    chk("run_t4_busy", {63'b0, o_busy}, 64'd0);

    // Overfill lane1 weights, then stream all four.
    for (int i = 0; i < 4; i++) issue(2, 1, 16'h1001 + i);
    issue(2, 1, 16'h1005);
    chk("overfill_err", {63'b0, o_err}, 64'd1);
    for (int i = 0; i < 4; i++) issue(2, 0, 16'h2001 + i);
    issue(5, 0, 4);
    chk("runw_lane0_first", {48'b0, o_wd[15:0]}, 64'h2001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("runw_lane1_order", {48'b0, o_wd[31:16]}, 64'h1001 + i);
    end
    wait_idle();

    // Short lane rejects the whole run; CLEAR empties everything.
    for (int i = 0; i < 3; i++) issue(1, 0, 16'h0031 + i);
    issue(1, 1, 16'h0041);
    issue(4, 0, 2);
    chk("short_err", {63'b0, o_err}, 64'd1);
    chk("short_no_valid", {60'b0, o_fv}, 64'd0);
    issue(7, 0, 0);
    issue(4, 0, 1);
    chk("clear_err", {63'b0, o_err}, 64'd1);

    // Back-to-back bias load and switch.
    issue(3, 0, 16'hFF80);
    chk("bias_pulse", {47'b0, o_bias_load, o_bias}, 64'h1_FF80);
    chk("bias_no_switch", {63'b0, o_switch}, 64'd0);
    issue(6, 0, 0);
    chk("switch_pulse", {63'b0, o_switch}, 64'd1);
    chk("bias_one_cycle", {63'b0, o_bias_load}, 64'd0);
    tick();
    chk("switch_one_cycle", {63'b0, o_switch}, 64'd0);

    for (int n = 0; n < 300; n++) rand_instr();
    wait_idle();

    // Wider instance: reset mid-stream, then check pointer wrap.
    rst = 1'b0;
    tick();
    sel = 1'b1; L = 4; D = 8;
    tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) issue(1, k, 16'hA000 + k * 16 + i);
    issue(4, 0, 8);
    begin
      int guard;
      guard = 0;
      while (m_s != 5 && guard < 20) begin tick(); guard++; end
    end
    chk("pre_reset_valid", {60'b0, o_fv}, 64'hF);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_valid", {60'b0, o_fv}, 64'd0);
    chk("async_reset_data", o_fd, 64'd0);
    chk("async_reset_busy", {63'b0, o_busy}, 64'd0);
    chk("async_reset_ready", {63'b0, o_ready}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ready_after_release", {63'b0, o_ready}, 64'd1);
    issue(4, 0, 1);
    chk("empty_after_reset_err", {63'b0, o_err}, 64'd1);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 6; i++) issue(1, k, 16'hB000 + k * 16 + i);
    issue(4, 0, 6);
    wait_idle();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) issue(1, k, 16'hC000 + k * 16 + i);
    issue(4, 0, 8);
    chk("wrap_lane0_first", {48'b0, o_fd[15:0]}, 64'hC000);
    wait_idle();

    for (int n = 0; n < 300; n++) rand_instr();
    wait_idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nn_feeder.md
# nn_feeder

Parametrised, instruction-driven front end for the N-lane systolic datapath. It generalises the fixed two-address load routing of the 2x2 top level to `LANES` lanes. Each lane has a `DEPTH`-entry input FIFO and a `DEPTH`-entry weight FIFO, which it fills from a valid/ready instruction stream. It then streams them into the array with a one-cycle-per-lane diagonal skew, which replaces the chained valid/start handoff between accumulators. Bias loads and the weight switch pulse are also issued here.

## Interface
Parameters:
- `LANES`, 2: number of array rows/columns fed; ≥1
- `DEPTH`, 4: entries per lane FIFO (input and weight each); power of two, ≥2
- `DW`, 16: data width, signed fixed point, passed through unmodified
- `AW`, `$clog2(LANES)` (min 1): lane address width, derived

Ports:
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `instr_valid` in 1: instruction present
- `instr_ready` out 1: instruction accepted on an edge where valid&&ready
- `instr_op` in 3: 0 NOP, 1 LOAD_IN, 2 LOAD_W, 3 LOAD_BIAS, 4 RUN_IN, 5 RUN_W, 6 SWITCH, 7 CLEAR
- `instr_addr` in AW: target lane for LOAD_IN/LOAD_W
- `instr_data` in DW: payload, or vector count (low `$clog2(DEPTH)+1` bits, unsigned) for RUN_*
- `feed_data` out LANES*DW: input stream, lane k at [k*DW +: DW]
- `feed_valid` out LANES: per-lane input valid
- `weight_data` out LANES*DW: weight stream, same packing
- `weight_valid` out LANES: per-lane weight valid (array accept_w)
- `bias_data` out DW: bias scalar
- `bias_load` out 1: bias scalar valid, one-cycle pulse
- `switch_out` out 1: weight switch, one-cycle pulse
- `busy` out 1: streaming in progress
- `err` out 1: one-cycle pulse when an instruction is rejected

## Operation
- FSM states: IDLE, STREAM_IN, STREAM_W.
- `instr_ready` is 1 only in IDLE with `rst` high. Every accepted instruction takes effect on its acceptance edge.
- LOAD_IN / LOAD_W:
  - Push `instr_data` into the addressed lane's FIFO.
  - Rejected with `err`, no state change, if `instr_addr ≥ LANES` or that FIFO is full.
- LOAD_BIAS: `bias_data` = payload and `bias_load` = 1 for exactly one cycle.
- SWITCH: `switch_out` = 1 for one cycle.
- CLEAR: all FIFO occupancies go to 0. Data contents are don't-care.
- RUN_IN / RUN_W with count C:
  - C = 0: NOP.
  - Rejected with `err` if C exceeds the occupancy of any lane's corresponding FIFO. All lanes are checked, not only lane 0.
  - Otherwise the FSM enters STREAM_IN or STREAM_W, `busy` = 1, and skew counter s clears to 0.
  - Lane k pops and presents one entry per cycle while k ≤ s < k+C. Valid is high in exactly those cycles and data holds the popped entry.
  - Data outside valid cycles is 0.
  - The state returns to IDLE after s reaches C+LANES−2.
- FIFO order is strict first-in first-out per lane. Pointers wrap modulo DEPTH. Occupancy ranges 0..DEPTH.
- No arithmetic is performed. Data is bit-exact passthrough.
- Reset (asynchronous, any state, including mid-stream):
  - Outputs: all 0.
  - FSM: IDLE.
  - FIFOs: empty.
  - `instr_ready` goes high in the first cycle after `rst` deasserts.

## Timing
- LOAD/CLEAR/NOP:
  - Occupancy is updated on the acceptance edge.
  - A following RUN in the next cycle sees the new occupancy.
  - Throughput: one instruction per cycle.
- LOAD_BIAS/SWITCH/`err`: the pulse is high in the cycle immediately after the acceptance edge. All are registered.
- RUN accepted at edge t:
  - Lane k valid in cycles t+1+k … t+k+C.
  - `busy` is high for cycles t+1 … t+C+LANES−1.
  - `instr_ready` returns to 1 in cycle t+C+LANES.
- All outputs are registered. There are no combinational paths from inputs to outputs except `instr_ready` ← state and `rst`.
- A rejected instruction still consumes its handshake and produces `err` one cycle later.

## Test plan
- LANES=2, DEPTH=4:
  - Stimulus: LOAD_IN lane0 = 0x0100, 0x0200; lane1 = 0x0300, 0x0400; then RUN_IN C=2 accepted at edge t.
  - Required response: lane0 valid at t+1 and t+2 with 0x0100, 0x0200. Lane1 valid at t+2 and t+3 with 0x0300, 0x0400. `busy` high for 3 cycles. Ready high again at t+4.
- Fill lane1 weights ×4, then a 5th LOAD_W.
  - Required response: `err` pulse, occupancy stays 4. RUN_W C=4 streams all 4 in order.
- Lane0 has 3 inputs, lane1 has 1; RUN_IN C=2.
  - Required response: `err`, no valid pulses, occupancies unchanged. Then CLEAR followed by RUN_IN C=1 gives `err`.
- LOAD_BIAS 0xFF80 then SWITCH back-to-back.
  - Required response: `bias_load` with 0xFF80 one cycle, then `switch_out` the next cycle. Each pulse is exactly one cycle.
- LANES=4, DEPTH=8:
  - Stimulus: load 8 entries per lane, RUN_IN C=8, and assert `rst` low at s=5.
  - Required response: all outputs 0 immediately (asynchronous). After release, FIFOs are empty and ready = 1. A new load-then-run streams correctly, confirming pointer wrap.
